// File: rtl/dp_decode_stage.sv
// Registered ARM7TDMI data-processing decode stage with condition evaluation and saturating annul counter.
// Optional build macro DP_SKID_EN adds a one-entry skid buffer so in_ready has no path from out_ready.
module dp_decode_stage #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [3:0]         cpsr_nzcv,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_cond_pass,
    output logic               out_is_dp,
    output logic [3:0]         out_opcode,
    output logic               out_s,
    output logic               out_imm,
    output logic [REG_AW-1:0]  out_rn,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rm,
    output logic [11:0]        out_shift,
    output logic               out_rn_used,
    output logic               out_rd_write,
    output logic [CNT_W-1:0]   annul_cnt
);

    typedef struct packed {
        logic              cond_pass;
        logic              is_dp;
        logic [3:0]        opcode;
        logic              s;
        logic              imm;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rm;
        logic [11:0]       shift;
        logic              rn_used;
        logic              rd_write;
    } bundle_t;

    bundle_t          w_dec;
    bundle_t          r_out;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_annul;
    logic             w_accept;
    logic             w_n, w_z, w_c, w_v;

    // Condition evaluation and field extraction for the word on the input port
    always_comb begin
        {w_n, w_z, w_c, w_v} = cpsr_nzcv;
        w_dec                = '0;
        case (in_instr[31:28])
            4'h0:    w_dec.cond_pass = w_z;
            4'h1:    w_dec.cond_pass = ~w_z;
            4'h2:    w_dec.cond_pass = w_c;
            4'h3:    w_dec.cond_pass = ~w_c;
            4'h4:    w_dec.cond_pass = w_n;
            4'h5:    w_dec.cond_pass = ~w_n;
            4'h6:    w_dec.cond_pass = w_v;
            4'h7:    w_dec.cond_pass = ~w_v;
            4'h8:    w_dec.cond_pass = w_c & ~w_z;
            4'h9:    w_dec.cond_pass = ~w_c | w_z;
            4'hA:    w_dec.cond_pass = (w_n == w_v);
            4'hB:    w_dec.cond_pass = (w_n != w_v);
            4'hC:    w_dec.cond_pass = ~w_z & (w_n == w_v);
            4'hD:    w_dec.cond_pass = w_z | (w_n != w_v);
            4'hE:    w_dec.cond_pass = 1'b1;
            default: w_dec.cond_pass = 1'b0;
        endcase
        // Multiply/swap/halfword share the 00 class but set bits 7 and 4 with I clear;
        // MRS/MSR are the compare opcodes without S.
        w_dec.is_dp    = (in_instr[27:26] == 2'b00)
                       & ~(~in_instr[25] & in_instr[7] & in_instr[4])
                       & ~((in_instr[24:23] == 2'b10) & ~in_instr[20]);
        w_dec.opcode   = in_instr[24:21];
        w_dec.s        = in_instr[20];
        w_dec.imm      = in_instr[25];
        w_dec.rn       = REG_AW'(in_instr[19:16]);
        w_dec.rd       = REG_AW'(in_instr[15:12]);
        w_dec.rm       = REG_AW'(in_instr[3:0]);
        w_dec.shift    = in_instr[11:0];
        w_dec.rn_used  = w_dec.is_dp & (in_instr[24:21] != 4'b1101) & (in_instr[24:21] != 4'b1111);
        w_dec.rd_write = w_dec.is_dp & w_dec.cond_pass & (in_instr[24:23] != 2'b10);
    end

`ifdef DP_SKID_EN
    bundle_t r_skid;
    logic    r_skid_valid;
    logic    w_out_free;

    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid & ~flush;
    assign w_out_free = ~r_out_valid | out_ready;

    // Output register fed from skid first so ordering is preserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    // Single output register; flush overrides any same-edge accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Saturating count of accepted condition-failed instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_annul <= '0;
        end else if (w_accept && !w_dec.cond_pass && (r_annul != {CNT_W{1'b1}})) begin
            r_annul <= r_annul + CNT_W'(1);
        end
    end

    assign out_valid     = r_out_valid;
    assign out_cond_pass = r_out.cond_pass;
    assign out_is_dp     = r_out.is_dp;
    assign out_opcode    = r_out.opcode;
    assign out_s         = r_out.s;
    assign out_imm       = r_out.imm;
    assign out_rn        = r_out.rn;
    assign out_rd        = r_out.rd;
    assign out_rm        = r_out.rm;
    assign out_shift     = r_out.shift;
    assign out_rn_used   = r_out.rn_used;
    assign out_rd_write  = r_out.rd_write;
    assign annul_cnt     = r_annul;

endmodule
